spi_master_core: RTL and testbench



---
 rtl/spi_master_pkg.sv | 13 +
 rtl/spi_clk_gen.sv | 53 +++++
 rtl/spi_master_core.sv | 132 +++++++++++++
 tb/tb_spi_master_core.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_master_pkg.sv
// Shared types and widths for the single-byte SPI master.
// Bit order is chosen at build time with SPI_LSB_FIRST_EN (see spi_master_core).
package spi_master_pkg;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned BIT_CNT_W = $clog2(DATA_W);

    typedef enum logic {
        IDLE,
        XFER
    } state_e;

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK generator: counts clk_div system cycles per half-period while enabled,
// toggles sclk and flags the rising/falling edge in the cycle it happens.
// Disabling returns the divider and sclk to their idle values.
module spi_clk_gen #(
    parameter int unsigned clk_div = 4
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic en_i,
    output logic sclk_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned           CNT_W   = (clk_div > 1) ? $clog2(clk_div) : 1;
    localparam logic [CNT_W-1:0]      CNT_MAX = CNT_W'(clk_div - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sclk_q, sclk_d;
    logic             tick;

    // Divider next-state and edge flags.
    always_comb begin
        tick   = en_i && (cnt_q == CNT_MAX);
        cnt_d  = cnt_q;
        sclk_d = sclk_q;
        if (!en_i) begin
            cnt_d  = '0;
            sclk_d = 1'b0;
        end else if (tick) begin
            cnt_d  = '0;
            sclk_d = ~sclk_q;
        end else begin
            cnt_d  = cnt_q + 1'b1;
        end
    end

    // Divider and sclk registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

    assign sclk_o = sclk_q;
    assign rise_o = tick & ~sclk_q;
    assign fall_o = tick &  sclk_q;

endmodule

// File: rtl/spi_master_core.sv
// Single-byte SPI master, mode 0, one chip select.
// Define SPI_LSB_FIRST_EN for LSB-first order; default is MSB-first.
module spi_master_core
    import spi_master_pkg::*;
#(
    parameter int unsigned clk_div = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    output logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic              done,
    input  logic              miso,
    output logic              mosi,
    output logic              sclk,
    output logic              cs
);

    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_W - 1);

    state_e                state_q, state_d;
    logic [DATA_W-1:0]     tx_q, tx_d;
    logic [DATA_W-1:0]     rx_sh_q, rx_sh_d;
    logic [DATA_W-1:0]     rx_data_q, rx_data_d;
    logic [BIT_CNT_W-1:0]  bit_q, bit_d;
    logic                  cs_q, cs_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  clk_en, sclk_rise, sclk_fall;

    assign clk_en = (state_q == XFER);

    spi_clk_gen #(
        .clk_div(clk_div)
    ) u_clk_gen (
        .clk_i  (clk),
        .reset_i(reset),
        .en_i   (clk_en),
        .sclk_o (sclk),
        .rise_o (sclk_rise),
        .fall_o (sclk_fall)
    );

    // Transfer sequencing: accept, sample on rise, shift on fall, finish on 8th fall.
    always_comb begin
        state_d   = state_q;
        tx_d      = tx_q;
        rx_sh_d   = rx_sh_q;
        rx_data_d = rx_data_q;
        bit_d     = bit_q;
        cs_d      = cs_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    tx_d    = tx_data;
                    rx_sh_d = '0;
                    bit_d   = '0;
                    cs_d    = 1'b0;
                    busy_d  = 1'b1;
                    state_d = XFER;
                end
            end
            XFER: begin
                if (sclk_rise) begin
`ifdef SPI_LSB_FIRST_EN
                    rx_sh_d = {miso, rx_sh_q[DATA_W-1:1]};
`else
                    rx_sh_d = {rx_sh_q[DATA_W-2:0], miso};
`endif
                end
                if (sclk_fall) begin
                    if (bit_q == LAST_BIT) begin
                        rx_data_d = rx_sh_q;
                        tx_d      = '0;
                        done_d    = 1'b1;
                        busy_d    = 1'b0;
                        cs_d      = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        bit_d = bit_q + 1'b1;
`ifdef SPI_LSB_FIRST_EN
                        tx_d  = {1'b0, tx_q[DATA_W-1:1]};
`else
                        tx_d  = {tx_q[DATA_W-2:0], 1'b0};
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            tx_q      <= '0;
            rx_sh_q   <= '0;
            rx_data_q <= '0;
            bit_q     <= '0;
            cs_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_q      <= tx_d;
            rx_sh_q   <= rx_sh_d;
            rx_data_q <= rx_data_d;
            bit_q     <= bit_d;
            cs_q      <= cs_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // mosi is the outgoing end of the TX register, which is cleared when idle.
`ifdef SPI_LSB_FIRST_EN
    assign mosi = tx_q[0];
`else
    assign mosi = tx_q[DATA_W-1];
`endif

    assign rx_data = rx_data_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign cs      = cs_q;

endmodule

// File: tb/tb_spi_master_core.sv
// Directed bench for spi_master_core (default MSB-first build).
module tb_spi_master_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic [7:0] rx_data;
    logic       busy, done, mosi, sclk, cs;
    logic       miso = 1'b0;

    logic       start2 = 1'b0;
    logic [7:0] tx2 = 8'h00;
    logic [7:0] rx2;
    logic       busy2, done2, mosi2, sclk2, cs2;
    logic       miso2 = 1'b1;

    spi_master_core #(.clk_div(4)) dut (
        .clk(clk), .reset(reset), .start(start), .tx_data(tx_data),
        .rx_data(rx_data), .busy(busy), .done(done), .miso(miso),
        .mosi(mosi), .sclk(sclk), .cs(cs)
    );

    spi_master_core #(.clk_div(1)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .tx_data(tx2),
        .rx_data(rx2), .busy(busy2), .done(done2), .miso(miso2),
        .mosi(mosi2), .sclk(sclk2), .cs(cs2)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    // Slave side of dut: mode 0 loops mosi back, mode 1 shifts out slave_byte MSB-first.
    int         mode       = 0;
    logic [7:0] slave_byte = 8'h00;
    logic [7:0] slave_sh   = 8'h00;
    logic [7:0] mosi_log   = 8'h00;
    logic       sclk_prev  = 1'b0;
    logic       mosi_prev  = 1'b0;
    int         rise_cnt   = 0;
    int         done_cnt   = 0;

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (!sclk_prev && sclk) begin
            rise_cnt++;
            mosi_log = {mosi_log[6:0], mosi_prev};
        end
        if (!busy) begin
            slave_sh = slave_byte;
            miso     = (mode == 1) ? slave_byte[7] : 1'b0;
        end else if (sclk_prev && !sclk) begin
            if (mode == 1) begin
                slave_sh = {slave_sh[6:0], 1'b0};
                miso     = slave_sh[7];
            end else begin
                miso = mosi_prev;
            end
        end
        sclk_prev = sclk;
        mosi_prev = mosi;
    end

    task automatic do_start(input logic [7:0] d);
        @(negedge clk);
        tx_data = d;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cyc);
        cyc = 0;
        while (cyc < budget) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done) break;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cyc;
        int r0;
        int d0;

        // Reset state
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_cs",   32'(cs),      32'd1);
        check("rst_sclk", 32'(sclk),    32'd0);
        check("rst_busy", 32'(busy),    32'd0);
        check("rst_done", 32'(done),    32'd0);
        check("rst_rx",   32'(rx_data), 32'h00);
        check("rst_mosi", 32'(mosi),    32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Loopback 0xA5
        mode = 0;
        repeat (2) @(negedge clk);
        r0 = rise_cnt;
        do_start(8'hA5);
        check("lb_busy_e0", 32'(busy), 32'd1);
        check("lb_cs_e0",   32'(cs),   32'd0);
        check("lb_mosi_e0", 32'(mosi), 32'd1);
        tx_data = 8'h00;
        wait_done(200, cyc);
        check("lb_latency", 32'(cyc),      32'd64);
        check("lb_rx",      32'(rx_data),  32'h52);
        check("lb_busy",    32'(busy),     32'd0);
        check("lb_cs",      32'(cs),       32'd1);
        check("lb_mosi",    32'(mosi),     32'd0);
        check("lb_pulses",  32'(rise_cnt - r0), 32'd8);
        check("lb_mosi_bits", 32'(mosi_log), 32'hA5);
        @(posedge clk);
        #1;
        check("lb_done_clr", 32'(done), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        check("lb_rx_hold", 32'(rx_data), 32'h52);

        // Slave drives 0x3C
        mode = 1;
        slave_byte = 8'h3C;
        repeat (2) @(negedge clk);
        do_start(8'h00);
        wait_done(200, cyc);
        check("sl_latency", 32'(cyc),     32'd64);
        check("sl_rx",      32'(rx_data), 32'h3C);

        // start pulsed mid-transfer is ignored
        mode = 0;
        repeat (2) @(negedge clk);
        d0 = done_cnt;
        do_start(8'hC3);
        repeat (29) @(posedge clk);
        @(negedge clk);
        start   = 1'b1;
        tx_data = 8'hFF;
        @(negedge clk);
        start   = 1'b0;
        wait_done(200, cyc);
        check("bi_rx",        32'(rx_data),  32'h61);
        check("bi_mosi_bits", 32'(mosi_log), 32'hC3);
        repeat (80) @(posedge clk);
        #1;
        check("bi_one_done", 32'(done_cnt - d0), 32'd1);
        check("bi_idle",     32'(busy),          32'd0);

        // Reset abort at cycle 20
        d0 = done_cnt;
        do_start(8'h5A);
        repeat (19) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("ab_cs",   32'(cs),      32'd1);
        check("ab_sclk", 32'(sclk),    32'd0);
        check("ab_busy", 32'(busy),    32'd0);
        check("ab_rx",   32'(rx_data), 32'h00);
        check("ab_mosi", 32'(mosi),    32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (80) @(posedge clk);
        #1;
        check("ab_no_done", 32'(done_cnt - d0), 32'd0);
        check("ab_cs_idle", 32'(cs),            32'd1);

        // Back-to-back with clk_div = 1, miso held high
        @(negedge clk);
        tx2    = 8'h12;
        start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        check("bb_busy_e0", 32'(busy2), 32'd1);
        cyc = 0;
        while (cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done2) break;
        end
        check("bb_first_done", 32'(cyc), 32'd16);
        check("bb_first_rx",   32'(rx2), 32'hFF);
        start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        cyc++;
        check("bb_restart_busy", 32'(busy2), 32'd1);
        check("bb_restart_cs",   32'(cs2),   32'd0);
        check("bb_done_clr",     32'(done2), 32'd0);
        while (cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done2) break;
        end
        check("bb_second_done", 32'(cyc), 32'd33);
        check("bb_second_rx",   32'(rx2), 32'hFF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
